// File: rtl/spi_slave.sv
// SPI responder: synchronizes SCLK/CS_n/MOSI into sysclk, all four CPOL/CPHA modes, N-bit words.
// Define SPI_SLAVE_LSB_FIRST_EN to shift LSB first; MSB first otherwise.
module spi_slave #(
  parameter int unsigned N = 8
) (
  input  logic         i_sysclk,
  input  logic         rst_n,
  input  logic         i_enable,
  input  logic         i_cpol,
  input  logic         i_cpha,
  input  logic         i_sclk,
  input  logic         i_cs_n,
  input  logic         i_mosi,
  output logic         o_miso,
  output logic         o_miso_oe,
  input  logic [N-1:0] i_tx_data,
  input  logic         i_tx_load,
  output logic         o_tx_ready,
  output logic [N-1:0] o_rx_data,
  output logic         o_rx_valid,
  input  logic         i_rx_ack,
  output logic         o_overrun,
  output logic         o_underrun,
  output logic         o_busy
);

  localparam int unsigned CntW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(N - 1);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e          r_state;
  logic            r_busy;
  logic [CntW-1:0] r_cnt;
  logic [N-1:0]    r_rx_sr;
  logic [N-1:0]    r_tx_sr;
  logic [N-1:0]    r_tx_hold;
  logic            r_tx_full;
  logic            r_miso;
  logic [N-1:0]    r_rx_data;
  logic            r_rx_valid;
  logic            r_overrun;
  logic            r_underrun;
  logic            r_sample_p;
  logic            r_shift_p;

  logic r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic r_cs_s1, r_cs_s2, r_cs_s3;
  logic r_mosi_s1, r_mosi_s2, r_mosi_s3;

  // CS_n synchronizers reset low so a select held through reset is not mistaken for a new fall.
  always_ff @(posedge i_sysclk or negedge rst_n) begin
    if (!rst_n) begin
      {r_sclk_s3, r_sclk_s2, r_sclk_s1} <= 3'b000;
      {r_cs_s3, r_cs_s2, r_cs_s1}       <= 3'b000;
      {r_mosi_s3, r_mosi_s2, r_mosi_s1} <= 3'b000;
    end else begin
      {r_sclk_s3, r_sclk_s2, r_sclk_s1} <= {r_sclk_s2, r_sclk_s1, i_sclk};
      {r_cs_s3, r_cs_s2, r_cs_s1}       <= {r_cs_s2, r_cs_s1, i_cs_n};
      {r_mosi_s3, r_mosi_s2, r_mosi_s1} <= {r_mosi_s2, r_mosi_s1, i_mosi};
    end
  end

  logic w_sclk_rise, w_sclk_fall, w_lead, w_trail;
  logic w_sample_edge, w_shift_edge, w_cs_fall, w_word_done, w_start;

  assign w_sclk_rise   = r_sclk_s2 & ~r_sclk_s3;
  assign w_sclk_fall   = ~r_sclk_s2 & r_sclk_s3;
  assign w_lead        = i_cpol ? w_sclk_fall : w_sclk_rise;
  assign w_trail       = i_cpol ? w_sclk_rise : w_sclk_fall;
  assign w_sample_edge = i_cpha ? w_trail : w_lead;
  assign w_shift_edge  = i_cpha ? w_lead : w_trail;
  assign w_cs_fall     = r_cs_s3 & ~r_cs_s2;

  assign w_word_done = (r_state == StActive) && !r_cs_s2 && r_sample_p && (r_cnt == CntMax);
  assign w_start     = i_enable && (((r_state == StIdle) && w_cs_fall) || w_word_done);

  logic [N-1:0] w_load_word, w_load_rest, w_sr_rest, w_rx_next;
  logic         w_load_first, w_sr_first;

  assign w_load_word = r_tx_full ? r_tx_hold : '0;

`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign w_load_first = w_load_word[0];
  assign w_load_rest  = w_load_word >> 1;
  assign w_sr_first   = r_tx_sr[0];
  assign w_sr_rest    = r_tx_sr >> 1;
  assign w_rx_next    = {r_mosi_s3, r_rx_sr[N-1:1]};
`else
  assign w_load_first = w_load_word[N-1];
  assign w_load_rest  = w_load_word << 1;
  assign w_sr_first   = r_tx_sr[N-1];
  assign w_sr_rest    = r_tx_sr << 1;
  assign w_rx_next    = {r_rx_sr[N-2:0], r_mosi_s3};
`endif

  always_ff @(posedge i_sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_busy     <= 1'b0;
      r_cnt      <= '0;
      r_rx_sr    <= '0;
      r_tx_sr    <= '0;
      r_tx_hold  <= '0;
      r_tx_full  <= 1'b0;
      r_miso     <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
      r_sample_p <= 1'b0;
      r_shift_p  <= 1'b0;
    end else begin
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
      r_sample_p <= w_sample_edge;
      r_shift_p  <= w_shift_edge;

      if (!i_enable) begin
        r_state    <= StIdle;
        r_busy     <= 1'b0;
        r_cnt      <= '0;
        r_rx_sr    <= '0;
        r_tx_sr    <= '0;
        r_miso     <= 1'b0;
        r_rx_data  <= '0;
        r_rx_valid <= 1'b0;
      end else begin
        if (i_rx_ack && r_rx_valid) r_rx_valid <= 1'b0;
        case (r_state)
          StIdle: begin
            if (w_cs_fall) begin
              r_state <= StActive;
              r_busy  <= 1'b1;
              r_cnt   <= '0;
              r_rx_sr <= '0;
            end
          end
          StActive: begin
            if (r_cs_s2) begin
              r_state <= StIdle;
              r_busy  <= 1'b0;
              r_cnt   <= '0;
              r_rx_sr <= '0;
              r_tx_sr <= '0;
              r_miso  <= 1'b0;
            end else begin
              if (r_sample_p) begin
                r_rx_sr <= w_rx_next;
                if (r_cnt == CntMax) begin
                  r_cnt      <= '0;
                  r_rx_data  <= w_rx_next;
                  r_rx_valid <= 1'b1;
                  r_overrun  <= r_rx_valid && !i_rx_ack;
                end else begin
                  r_cnt <= r_cnt + 1'b1;
                end
              end
              // CPHA=0: the shift edge right after a word boundary keeps the freshly presented bit.
              if (r_shift_p && (i_cpha || (r_cnt != '0))) begin
                r_miso  <= w_sr_first;
                r_tx_sr <= w_sr_rest;
              end
            end
          end
          default: r_state <= StIdle;
        endcase

        if (w_start) begin
          r_tx_sr    <= i_cpha ? w_load_word : w_load_rest;
          r_underrun <= !r_tx_full;
          r_tx_full  <= 1'b0;
          if (!i_cpha) r_miso <= w_load_first;
        end
      end

      // Placed last so a load coinciding with a word start still captures the new word.
      if (i_tx_load && !r_tx_full) begin
        r_tx_hold <= i_tx_data;
        r_tx_full <= 1'b1;
      end
    end
  end

  assign o_miso     = r_miso;
  assign o_miso_oe  = r_busy;
  assign o_busy     = r_busy;
  assign o_tx_ready = !r_tx_full;
  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;
  assign o_overrun  = r_overrun;
  assign o_underrun = r_underrun;

endmodule
